// File: rtl/if_id_frontend.sv
// if_id_frontend: PC register, IF/ID pipeline latch and registered ID/EX
// bubble flag for the 5-stage RISC-V pipeline. The front end resolves the
// hazard unit's PCWrite/Stall/NoOp, the ID-stage branch flush and the
// data-memory stall in fixed priority order.
// Optional build macro: IF_ID_PERF_CNT_EN adds saturating stall, flush and
// freeze event counters.
module if_id_frontend #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        Stall_i,
    input  logic        NoOp_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    input  logic        MemStall_i,
    input  logic [31:0] Instr_i,
    output logic [31:0] PC_o,
    output logic [31:0] IFID_PC_o,
    output logic [31:0] IFID_Instr_o,
    output logic        IFID_Valid_o,
    output logic        IDEX_Bubble_o,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0] StallCnt_o,
    output logic [31:0] FlushCnt_o,
    output logic [31:0] FreezeCnt_o,
`endif
    output logic [1:0]  State_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FREEZE = 2'b10
    } state_t;

    state_t state;

    assign State_o = state;

    // Front-end FSM: IDLE waits for start, RUN applies MemStall > Stall > Flush > normal fetch,
    // FREEZE holds everything (including the bubble flag) until the data memory is free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            PC_o          <= RESET_PC;
            IFID_PC_o     <= 32'h00000000;
            IFID_Instr_o  <= NOP_INSTR;
            IFID_Valid_o  <= 1'b0;
            IDEX_Bubble_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (MemStall_i) begin
                        state <= FREEZE;
                    end else begin
                        IDEX_Bubble_o <= NoOp_i;
                        if (Stall_i) begin
                            // Branch operands are not valid during a load-use stall, so Flush_i is ignored.
                            if (PCWrite_i) begin
                                PC_o <= PC_o + PC_STEP;
                            end
                        end else if (Flush_i) begin
                            PC_o         <= BranchTarget_i;
                            IFID_PC_o    <= PC_o;
                            IFID_Instr_o <= NOP_INSTR;
                            IFID_Valid_o <= 1'b0;
                        end else begin
                            IFID_PC_o    <= PC_o;
                            IFID_Instr_o <= Instr_i;
                            IFID_Valid_o <= 1'b1;
                            if (PCWrite_i) begin
                                PC_o <= PC_o + PC_STEP;
                            end
                        end
                    end
                end
                FREEZE: begin
                    if (!MemStall_i) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic run_edge;
    logic stall_take;
    logic flush_take;
    logic freeze_edge;

    assign run_edge    = (state == RUN) && !MemStall_i;
    assign stall_take  = run_edge && Stall_i;
    assign flush_take  = run_edge && !Stall_i && Flush_i;
    assign freeze_edge = (state == FREEZE);

    // Saturating event counters: applied stalls, applied flushes and edges spent frozen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            StallCnt_o  <= 32'h00000000;
            FlushCnt_o  <= 32'h00000000;
            FreezeCnt_o <= 32'h00000000;
        end else begin
            if (stall_take && (StallCnt_o != 32'hFFFFFFFF)) begin
                StallCnt_o <= StallCnt_o + 32'd1;
            end
            if (flush_take && (FlushCnt_o != 32'hFFFFFFFF)) begin
                FlushCnt_o <= FlushCnt_o + 32'd1;
            end
            if (freeze_edge && (FreezeCnt_o != 32'hFFFFFFFF)) begin
                FreezeCnt_o <= FreezeCnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_frontend.sv
// tb_if_id_frontend: directed test of the IF/ID front end against a
// behavioural model, plus hand-computed literal checkpoints.
module tb_if_id_frontend;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        PCWrite_i;
    logic        Stall_i;
    logic        NoOp_i;
    logic        Flush_i;
    logic [31:0] BranchTarget_i;
    logic        MemStall_i;
    logic [31:0] Instr_i;
    logic [31:0] PC_o;
    logic [31:0] IFID_PC_o;
    logic [31:0] IFID_Instr_o;
    logic        IFID_Valid_o;
    logic        IDEX_Bubble_o;
    logic [1:0]  State_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] StallCnt_o;
    logic [31:0] FlushCnt_o;
    logic [31:0] FreezeCnt_o;
`endif

    int assertions = 0;
    int failures   = 0;
    bit compare_en = 1'b0;
    bit use_const  = 1'b1;

    if_id_frontend dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .PCWrite_i      (PCWrite_i),
        .Stall_i        (Stall_i),
        .NoOp_i         (NoOp_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .MemStall_i     (MemStall_i),
        .Instr_i        (Instr_i),
        .PC_o           (PC_o),
        .IFID_PC_o      (IFID_PC_o),
        .IFID_Instr_o   (IFID_Instr_o),
        .IFID_Valid_o   (IFID_Valid_o),
        .IDEX_Bubble_o  (IDEX_Bubble_o),
`ifdef IF_ID_PERF_CNT_EN
        .StallCnt_o     (StallCnt_o),
        .FlushCnt_o     (FlushCnt_o),
        .FreezeCnt_o    (FreezeCnt_o),
`endif
        .State_o        (State_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: either a fixed instruction or one derived from the address.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return use_const ? 32'h00500093 : (addr ^ 32'h00A00013);
    endfunction

    assign Instr_i = imem(PC_o);

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_valid;
    logic        m_bubble;
    int          m_state;
    longint      m_stall_cnt;
    longint      m_flush_cnt;
    longint      m_freeze_cnt;

    // Model: each edge applies the front-end rules to the sampled inputs.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h00000013;
            m_valid = 1'b0; m_bubble = 1'b0; m_state = 0;
            m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
        end else if (m_state == 0) begin
            if (start_i) m_state = 1;
        end else if (m_state == 2) begin
            m_freeze_cnt = (m_freeze_cnt < 64'hFFFFFFFF) ? m_freeze_cnt + 1 : m_freeze_cnt;
            if (!MemStall_i) m_state = 1;
        end else if (MemStall_i) begin
            m_state = 2;
        end else begin
            m_bubble = NoOp_i;
            if (Stall_i) begin
                m_stall_cnt = (m_stall_cnt < 64'hFFFFFFFF) ? m_stall_cnt + 1 : m_stall_cnt;
                if (PCWrite_i) m_pc = m_pc + 32'd4;
            end else if (Flush_i) begin
                m_flush_cnt = (m_flush_cnt < 64'hFFFFFFFF) ? m_flush_cnt + 1 : m_flush_cnt;
                m_ifid_pc = m_pc; m_ifid_instr = 32'h00000013; m_valid = 1'b0;
                m_pc = BranchTarget_i;
            end else begin
                m_ifid_pc = m_pc; m_ifid_instr = imem(m_pc); m_valid = 1'b1;
                if (PCWrite_i) m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT outputs must match the model.
    always @(negedge clk_i) begin
        if (compare_en) begin
            checkOutput("model_pc", PC_o, m_pc);
            checkOutput("model_ifid_pc", IFID_PC_o, m_ifid_pc);
            checkOutput("model_ifid_instr", IFID_Instr_o, m_ifid_instr);
            checkOutput("model_valid", {31'b0, IFID_Valid_o}, {31'b0, m_valid});
            checkOutput("model_bubble", {31'b0, IDEX_Bubble_o}, {31'b0, m_bubble});
            checkOutput("model_state", {30'b0, State_o}, m_state);
`ifdef IF_ID_PERF_CNT_EN
            checkOutput("model_stall_cnt", StallCnt_o, m_stall_cnt[31:0]);
            checkOutput("model_flush_cnt", FlushCnt_o, m_flush_cnt[31:0]);
            checkOutput("model_freeze_cnt", FreezeCnt_o, m_freeze_cnt[31:0]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input bit start, input bit pcw, input bit stall, input bit noop,
                                 input bit flush, input logic [31:0] target, input bit mstall);
        start_i = start; PCWrite_i = pcw; Stall_i = stall; NoOp_i = noop;
        Flush_i = flush; BranchTarget_i = target; MemStall_i = mstall;
        tick();
    endtask

    typedef struct {
        bit start; bit pcw; bit stall; bit noop; bit flush; logic [31:0] target; bit mstall;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_i = 1'b1; start_i = 1'b0; PCWrite_i = 1'b1; Stall_i = 1'b0; NoOp_i = 1'b0;
        Flush_i = 1'b0; BranchTarget_i = 32'h0; MemStall_i = 1'b0;
        #12;
        compare_en = 1'b1;
        checkOutput("reset_pc", PC_o, 32'h0);
        checkOutput("reset_instr", IFID_Instr_o, 32'h00000013);
        checkOutput("reset_valid", {31'b0, IFID_Valid_o}, 32'h0);
        checkOutput("reset_state", {30'b0, State_o}, 32'h0);
        rst_i = 1'b0;

        applyStimulus(1, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("start_state", {30'b0, State_o}, 32'h1);
        checkOutput("start_pc", PC_o, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("fetch1_pc", PC_o, 32'h4);
        checkOutput("fetch1_instr", IFID_Instr_o, 32'h00500093);
        checkOutput("fetch1_valid", {31'b0, IFID_Valid_o}, 32'h1);
        checkOutput("fetch1_ifid_pc", IFID_PC_o, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("fetch2_pc", PC_o, 32'h8);

        // Load-use stall with bubble
        applyStimulus(0, 0, 1, 1, 0, 32'h0, 0);
        checkOutput("stall_pc", PC_o, 32'h8);
        checkOutput("stall_ifid_pc", IFID_PC_o, 32'h4);
        checkOutput("stall_bubble", {31'b0, IDEX_Bubble_o}, 32'h1);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("post_stall_pc", PC_o, 32'hC);
        checkOutput("post_stall_bubble", {31'b0, IDEX_Bubble_o}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("pc_10", PC_o, 32'h10);

        // Branch flush
        applyStimulus(0, 1, 0, 0, 1, 32'h40, 0);
        checkOutput("flush_pc", PC_o, 32'h40);
        checkOutput("flush_instr", IFID_Instr_o, 32'h00000013);
        checkOutput("flush_valid", {31'b0, IFID_Valid_o}, 32'h0);
        checkOutput("flush_ifid_pc", IFID_PC_o, 32'h10);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("after_flush_pc", PC_o, 32'h44);

        // Stall and flush together: flush ignored
        applyStimulus(0, 0, 1, 0, 1, 32'h80, 0);
        checkOutput("stallflush_pc", PC_o, 32'h44);
        checkOutput("stallflush_ifid_pc", IFID_PC_o, 32'h40);
        checkOutput("stallflush_valid", {31'b0, IFID_Valid_o}, 32'h1);

        // Memory stall for three cycles
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 1);
        checkOutput("freeze_state", {30'b0, State_o}, 32'h2);
        applyStimulus(0, 1, 0, 1, 0, 32'h0, 1);
        applyStimulus(0, 1, 0, 1, 0, 32'h0, 1);
        checkOutput("freeze_pc", PC_o, 32'h44);
        checkOutput("freeze_bubble", {31'b0, IDEX_Bubble_o}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("unfreeze_state", {30'b0, State_o}, 32'h1);
        checkOutput("unfreeze_pc", PC_o, 32'h44);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("resume_pc", PC_o, 32'h48);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("freeze_cnt", FreezeCnt_o, 32'd3);
        checkOutput("stall_cnt", StallCnt_o, 32'd2);
        checkOutput("flush_cnt", FlushCnt_o, 32'd1);
`endif

        // PC wrap
        applyStimulus(0, 1, 0, 0, 1, 32'hFFFFFFF8, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("pre_wrap_pc", PC_o, 32'hFFFFFFFC);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        checkOutput("wrap_pc", PC_o, 32'h0);

        // Async reset mid-freeze with a wrap pending
        applyStimulus(0, 1, 0, 0, 1, 32'hFFFFFFFC, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 1);
        checkOutput("freeze2_state", {30'b0, State_o}, 32'h2);
        #1 rst_i = 1'b1;
        #1;
        checkOutput("async_rst_pc", PC_o, 32'h0);
        checkOutput("async_rst_state", {30'b0, State_o}, 32'h0);
        checkOutput("async_rst_valid", {31'b0, IFID_Valid_o}, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("async_rst_freeze_cnt", FreezeCnt_o, 32'h0);
`endif
        rst_i = 1'b0;
        MemStall_i = 1'b0;

        // Unaligned branch target and mixed vectors, address-dependent instructions
        use_const = 1'b0;
        applyStimulus(1, 1, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'h00000103, 0);
        checkOutput("unaligned_pc", PC_o, 32'h00000103);
        vecs = '{
            '{0, 1, 0, 0, 0, 32'h0, 0},
            '{0, 1, 0, 1, 0, 32'h0, 0},
            '{0, 0, 0, 0, 0, 32'h0, 0},
            '{0, 1, 1, 1, 0, 32'h0, 0},
            '{0, 1, 0, 0, 1, 32'h200, 1},
            '{0, 1, 0, 0, 1, 32'h200, 0},
            '{0, 1, 0, 0, 1, 32'h200, 0},
            '{0, 1, 0, 1, 0, 32'h0, 0},
            '{0, 0, 1, 0, 0, 32'h0, 0},
            '{0, 1, 0, 0, 0, 32'h0, 0},
            '{0, 1, 0, 1, 0, 32'h0, 1},
            '{0, 1, 0, 0, 0, 32'h0, 0}
        };
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].start, vecs[i].pcw, vecs[i].stall, vecs[i].noop,
                          vecs[i].flush, vecs[i].target, vecs[i].mstall);
        end
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        #1;
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
